// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N upstream channels, the round-robin mux and one downstream sink.
// The slave modport is the mux side; the master modport is the side that drives the channels and the sink ready.
interface rr_stream_mux_if #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 8
);
    localparam int N = 1 << ADDRESS_WIDTH;

    logic [N-1:0]            i_valid;
    logic [N*DATA_WIDTH-1:0] i_data;
    logic [N-1:0]            o_ready;
    logic                    o_valid;
    logic [DATA_WIDTH-1:0]   o_data;
    logic [ADDRESS_WIDTH-1:0] o_address;
    logic                    i_ready;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_address
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_address
    );
endinterface

// File: rtl/rr_stream_mux.sv
// Round-robin N:1 stream mux with a single registered output beat.
// A beat can be accepted in the same cycle the held beat leaves, so a busy sink sees one beat per cycle.
module rr_stream_mux #(
    parameter int ADDRESS_WIDTH = 2,
    parameter int DATA_WIDTH    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rr_stream_mux_if.slave bus
);
    localparam int N = 1 << ADDRESS_WIDTH;

    typedef logic [ADDRESS_WIDTH-1:0] idx_t;

    idx_t                  last_grant_q, last_grant_d;
    idx_t                  out_addr_q,   out_addr_d;
    logic                  out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;

    idx_t                  winner;
    logic                  any_valid;
    logic                  out_free;
    logic                  take;
    logic [N-1:0]          grant;

    // Walk the offsets from farthest to nearest so the nearest requester after
    // last_grant is written last and wins; offset N wraps back to last_grant itself.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and every output gets a
        // default first, so no path leaves a value unassigned and no latch is inferred.
        winner    = last_grant_q;
        any_valid = 1'b0;
        for (int off = N; off >= 1; off--) begin
            idx_t cand;
            cand = last_grant_q + idx_t'(off);
            if (bus.i_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign out_free = !out_valid_q || bus.i_ready;
    // Reset gates the grant directly so o_ready is quiet while i_rst_n is low.
    assign take     = any_valid && out_free && i_rst_n;

    always_comb begin
        grant = '0;
        if (take) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.o_ready = grant;

    always_comb begin
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_addr_d   = out_addr_q;
        if (take) begin
            last_grant_d = winner;
            out_valid_d  = 1'b1;
            out_data_d   = bus.i_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            out_addr_d   = winner;
        end else if (out_valid_q && bus.i_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking '<=' only; the payload register is
    // reset too, because o_data must read zero while reset is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q <= idx_t'(N - 1);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign bus.o_valid   = out_valid_q;
    assign bus.o_data    = out_data_q;
    assign bus.o_address = out_addr_q;

    // Design invariants, checked in simulation only by tools that honour assertions.
    a_ready_onehot : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(bus.o_ready)
    );

    a_ready_quiet_when_stalled : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (out_valid_q && !bus.i_ready) |-> (bus.o_ready == '0)
    );

    a_hold_while_stalled : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (out_valid_q && !bus.i_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_addr_q))
    );

    a_load_next_cycle : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        take |=> (out_valid_q && out_addr_q == $past(winner)
                  && last_grant_q == $past(winner))
    );

    a_grant_only_on_transfer : assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !take |=> $stable(last_grant_q)
    );
endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomised and directed bench for rr_stream_mux against a queue-based round-robin model.
// The model tracks the output beat, the last grant and a scoreboard of accepted beats.
module tb_rr_stream_mux;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rr_stream_mux #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         m_lg;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_addr;
    beat_t      sb[$];
    int         wait_cnt[N];
    int         worst_wait;

    function automatic void model_reset();
        m_lg    = N - 1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_addr  = 0;
        sb.delete();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endfunction

    // First requesting channel at or after (last grant + 1) mod N, or -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int lg);
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (lg + off) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: drive at the falling edge, check before the rising edge, advance the model on it.
    task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
        int         w;
        bit         free;
        logic [N-1:0] exp_rdy;
        logic [7:0] obs_d;
        int         obs_a;
        beat_t      b;

        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = r;
        #1;
        check("o_valid",   32'(bus.o_valid),   32'(m_valid));
        check("o_data",    32'(bus.o_data),    32'(m_data));
        check("o_address", 32'(bus.o_address), 32'(m_addr));
        free    = !m_valid || r;
        w       = pick(v, m_lg);
        exp_rdy = '0;
        if (free && w >= 0) exp_rdy[w] = 1'b1;
        check("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
        obs_d = bus.o_data;
        obs_a = int'(bus.o_address);

        @(posedge clk);
        if (m_valid && r) begin
            if (sb.size() > 0) begin
                b = sb.pop_front();
                check("sb_data", 32'(obs_d), 32'(b.d));
                check("sb_addr", 32'(obs_a), 32'(b.ch));
            end
            m_valid = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (!v[k] || (free && w == k)) begin
                wait_cnt[k] = 0;
            end else if (free && w >= 0) begin
                wait_cnt[k]++;
                if (wait_cnt[k] > worst_wait) worst_wait = wait_cnt[k];
            end
        end
        if (free && w >= 0) begin
            b.ch    = w;
            b.d     = d[w*DW +: DW];
            sb.push_back(b);
            m_valid = 1'b1;
            m_data  = b.d;
            m_addr  = w;
            m_lg    = w;
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] PAY_A = 32'hA3A2A1A0;

    initial begin
        logic [N-1:0] rv;
        logic [31:0]  rd;
        logic         rr;

        worst_wait  = 0;
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        model_reset();

        // Reset held with every channel requesting: nothing may be granted.
        repeat (2) @(negedge clk);
        bus.i_valid = 4'b1111;
        bus.i_data  = PAY_A;
        bus.i_ready = 1'b1;
        #1;
        check("rst_o_ready", 32'(bus.o_ready), 32'h0);
        check("rst_o_valid", 32'(bus.o_valid), 32'h0);
        check("rst_o_data",  32'(bus.o_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        repeat (4) cycle(4'b0000, PAY_A, 1'b1);
        check("idle_o_ready", 32'(bus.o_ready), 32'h0);

        // All channels busy, sink always ready: strict 0,1,2,3,0 rotation with no bubbles
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, PAY_A, 1'b1);
            check("rr_valid", 32'(bus.o_valid),   32'h1);
            check("rr_addr",  32'(bus.o_address), 32'(i % N));
            check("rr_data",  32'(bus.o_data),    32'(8'hA0 + (i % N)));
        end
        cycle(4'b0000, PAY_A, 1'b1);

        // Single requester on channel 2 against a stalled sink
        cycle(4'b0100, 32'h005C0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0100, 32'h005C0000, 1'b0);
            check("stall_valid", 32'(bus.o_valid),   32'h1);
            check("stall_data",  32'(bus.o_data),    32'h5C);
            check("stall_addr",  32'(bus.o_address), 32'h2);
        end
        cycle(4'b0100, 32'h00C50000, 1'b1);
        check("pass_data", 32'(bus.o_data), 32'hC5);
        cycle(4'b0000, PAY_A, 1'b1);

        // Wrap: grant 3, then 0 and 3 alternate
        cycle(4'b1000, PAY_A, 1'b1);
        cycle(4'b1001, PAY_A, 1'b1);
        check("wrap_addr0", 32'(bus.o_address), 32'h0);
        cycle(4'b1001, PAY_A, 1'b1);
        check("wrap_addr3", 32'(bus.o_address), 32'h3);
        cycle(4'b1001, PAY_A, 1'b1);
        check("wrap_addr0b", 32'(bus.o_address), 32'h0);
        cycle(4'b0000, PAY_A, 1'b1);

        // Asynchronous reset while a beat is held
        cycle(4'b1111, 32'h77777777, 1'b0);
        check("held_data", 32'(bus.o_data), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_o_valid", 32'(bus.o_valid),   32'h0);
        check("arst_o_data",  32'(bus.o_data),    32'h0);
        check("arst_o_addr",  32'(bus.o_address), 32'h0);
        check("arst_o_ready", 32'(bus.o_ready),   32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1111, PAY_A, 1'b1);
        check("post_rst_addr", 32'(bus.o_address), 32'h0);
        check("post_rst_data", 32'(bus.o_data),    32'hA0);

        // Random traffic against the model and scoreboard
        for (int i = 0; i < 10000; i++) begin
            rv = N'($urandom);
            rd = $urandom;
            rr = ($urandom_range(0, 3) != 0);
            cycle(rv, rd, rr);
        end
        check("max_wait_ok", 32'(worst_wait < N), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
